// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC sequencer with IDLE/FETCH/HALT FSM feeding a small fetch queue
// Reads an asynchronous ROM at the PC and queues {pc, instr} pairs for a ready/valid consumer.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH    = 4,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] QD = (AW+1)'(QDEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t        state, state_next;
  logic [31:0]   pc;
  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  // Fullness is judged before any same-cycle pop, so a full queue never pushes.
  always_comb begin
    push = (state == FETCH) && fetch_en && (count < QD) && !redirect_valid;
    pop  = (count != '0) && out_ready && !redirect_valid;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_en) state_next = FETCH;
      FETCH: begin
        if (push && imem_data == HALT_WORD) state_next = HALT;
        else if (!fetch_en)                 state_next = IDLE;
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
    if (redirect_valid) state_next = fetch_en ? FETCH : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        pc     <= redirect_pc & 32'hFFFF_FFFC;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          pc     <= pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset; an empty queue masks its contents to zero.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= pc;
      q_instr[wr_ptr] <= imem_data;
    end
  end

  always_comb begin
    imem_addr = pc;
    out_valid = (count != '0);
    out_instr = out_valid ? q_instr[rd_ptr] : 32'h0;
    out_pc    = out_valid ? q_pc[rd_ptr]    : 32'h0;
    halted    = (state == HALT);
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - queue-level reference model plus directed scenarios for the fetch unit
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  logic [31:0] rom [256];
  assign imem_data = rom[imem_addr[9:2]];

  instruction_fetch_unit dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc,instr} pairs, a fetch address and a mode.
  localparam int M_IDLE = 0, M_FETCH = 1, M_HALT = 2;
  logic [63:0] mq [$];
  logic [31:0] m_pc;
  int          m_mode;
  bit          live = 1'b0;
  int          m_n;
  logic [31:0] m_word;
  bit          m_push;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0;
      mq.delete();
      m_mode = M_IDLE;
      live = 1'b1;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_mode = fetch_en ? M_FETCH : M_IDLE;
    end else begin
      m_n = mq.size();
      m_word = rom[m_pc[9:2]];
      m_push = (m_mode == M_FETCH) && fetch_en && (m_n < 4);
      if (m_n > 0 && out_ready) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back({m_pc, m_word});
        m_pc = m_pc + 32'd4;
      end
      if (m_mode != M_HALT)
        m_mode = (m_push && m_word == 32'hFFFF_FFFF) ? M_HALT : (fetch_en ? M_FETCH : M_IDLE);
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("model_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("model_imem_addr", imem_addr, m_pc);
      check("model_halted", 32'(halted), 32'(m_mode == M_HALT));
      if (mq.size() != 0) begin
        check("model_out_pc", out_pc, mq[0][63:32]);
        check("model_out_instr", out_instr, mq[0][31:0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h1000_0000 + i;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
    rom[255] = 32'hABCD_0000;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);

    // Sequential fetch with free-flowing consumer
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    cyc(2); @(negedge clk);
    check("seq_instr0", out_instr, 32'h11); check("seq_pc0", out_pc, 32'h0);
    cyc(1); @(negedge clk);
    check("seq_instr1", out_instr, 32'h22); check("seq_pc1", out_pc, 32'h4);
    cyc(1); @(negedge clk);
    check("seq_instr2", out_instr, 32'h33); check("seq_pc2", out_pc, 32'h8);
    cyc(1); @(negedge clk);
    check("seq_instr3", out_instr, 32'h44); check("seq_pc3", out_pc, 32'hC);

    // Backpressure fills the queue and freezes the PC
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    cyc(7); @(negedge clk);
    check("bp_out_valid", 32'(out_valid), 32'h1);
    check("bp_imem_addr", imem_addr, 32'h10);
    check("bp_head_instr", out_instr, 32'h11);
    check("bp_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    cyc(6);

    // Redirect flushes three queued entries
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    cyc(4);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    cyc(1);
    redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("redir_out_valid", 32'(out_valid), 32'h0);
    check("redir_imem_addr", imem_addr, 32'h40);
    cyc(1); @(negedge clk);
    check("redir_first_pc", out_pc, 32'h40);
    check("redir_first_instr", out_instr, 32'h1000_0010);
    cyc(3);

    // Halt word stops fetch after being queued
    rom[2] = 32'hFFFF_FFFF;
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    cyc(4); @(negedge clk);
    check("halt_last_pc", out_pc, 32'h8);
    check("halt_last_instr", out_instr, 32'hFFFF_FFFF);
    check("halt_flag", 32'(halted), 32'h1);
    cyc(5); @(negedge clk);
    check("halt_frozen_addr", imem_addr, 32'hC);
    check("halt_drained", 32'(out_valid), 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    cyc(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("halt_exit", 32'(halted), 32'h0);
    check("halt_exit_addr", imem_addr, 32'h100);
    cyc(3);
    rom[2] = 32'h33;

    // PC wraps past the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(1); @(negedge clk);
    check("wrap_pc_top", out_pc, 32'hFFFF_FFFC);
    check("wrap_instr_top", out_instr, 32'hABCD_0000);
    cyc(1); @(negedge clk);
    check("wrap_pc_zero", out_pc, 32'h0);

    // Redirect while IDLE loads the PC without fetching
    fetch_en = 1'b0;
    cyc(2);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(3); @(negedge clk);
    check("idle_redir_addr", imem_addr, 32'h80);
    check("idle_no_fetch", 32'(out_valid), 32'h0);

    // Reset overrides a same-cycle redirect with entries queued
    fetch_en = 1'b1; out_ready = 1'b0;
    cyc(3);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    cyc(1);
    rst = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_imem_addr", imem_addr, 32'h0);
    cyc(3); @(negedge clk);
    check("midrst_idle", 32'(out_valid), 32'h0);

    // Mixed enable, backpressure and redirect pattern
    for (int i = 0; i < 120; i++) begin
      fetch_en = (i % 7) != 0;
      out_ready = (i % 3) != 1;
      redirect_valid = (i % 29) == 17;
      redirect_pc = 32'(i * 12 + 1);
      cyc(1);
    end
    redirect_valid = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
